// File: rtl/gfx_sched_pkg.sv
// Shared constants, requester indices and fetch FSM state type for the
// graphics-ROM scheduler.
package gfx_sched_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  localparam int NREQ    = 3;
  localparam int REQ_FG  = 0;
  localparam int REQ_BG  = 1;
  localparam int REQ_SPR = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/gfx_sched_pick.sv
// Combinational winner select: sprite leads in blanking, the fg/bg pair
// (round-robin between them) leads during active display.
module gfx_sched_pick
  import gfx_sched_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_blank,
  input  logic            i_rr,
  output logic [NREQ-1:0] o_win,
  output logic            o_win_vld
);

  logic [NREQ-1:0] w_tile_win;
  logic            w_tile_any;
  logic            w_spr_wins;

  // i_rr low favours fg when both tile layers are asking
  always_comb begin
    w_tile_win = '0;
    if (i_req[REQ_FG] && (!i_req[REQ_BG] || !i_rr)) begin
      w_tile_win[REQ_FG] = 1'b1;
    end else if (i_req[REQ_BG]) begin
      w_tile_win[REQ_BG] = 1'b1;
    end
  end

  assign w_tile_any = i_req[REQ_FG] | i_req[REQ_BG];
  assign w_spr_wins = i_req[REQ_SPR] & (i_blank | ~w_tile_any);

  always_comb begin
    o_win = w_tile_win;
    if (w_spr_wins) begin
      o_win          = '0;
      o_win[REQ_SPR] = 1'b1;
    end
  end

  assign o_win_vld = |i_req;

endmodule

// File: rtl/gfx_rom_scheduler.sv
// Arbitrates the single graphics-ROM read port between fg, bg and sprite
// fetches against the raster, and issues the per-line sprite start strobe.
module gfx_rom_scheduler
  import gfx_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_pix,
  input  logic [8:0]        hc,
  input  logic [8:0]        vc,
  input  logic              hbl,
  input  logic              vbl,
  input  logic [NREQ-1:0]   req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [NREQ-1:0]   grant,
  output logic [DATA_W-1:0] dout,
  output logic [NREQ-1:0]   dvalid,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  output logic              spr_line_start,
  output logic [8:0]        spr_line,
  output logic              timeout_err
);

  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [NREQ-1:0]   r_owner;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_dvalid;
  logic [NREQ-1:0]   w_win;
  logic              w_win_vld;
  logic              r_rr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] r_dout;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_terr;
  logic              w_take;
  logic              w_deliver;
  logic              w_expire;
  logic              r_hbl_d;
  logic              r_spr_start;
  logic [8:0]        r_spr_line;
  logic              w_unused;

  // The horizontal counter is part of the raster bundle but scheduling only
  // needs the blanking flags and the line number.
  assign w_unused = ^hc;

  gfx_sched_pick u_pick (
    .i_req     (req),
    .i_blank   (hbl | vbl),
    .i_rr      (r_rr),
    .o_win     (w_win),
    .o_win_vld (w_win_vld)
  );

  always_comb begin
    w_win_addr = addr0;
    if (w_win[REQ_BG]) begin
      w_win_addr = addr1;
    end
    if (w_win[REQ_SPR]) begin
      w_win_addr = addr2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Delivery beats expiry when rom_valid lands on the last counted cycle.
  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_deliver  = 1'b0;
    w_expire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_take     = 1'b1;
          w_state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (rom_ack && rom_valid) begin
          w_deliver  = 1'b1;
          w_state_nx = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_expire   = 1'b1;
          w_state_nx = IDLE;
        end else if (rom_ack) begin
          w_state_nx = WAIT;
        end
      end
      WAIT: begin
        if (rom_valid) begin
          w_deliver  = 1'b1;
          w_state_nx = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_expire   = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner  <= '0;
      r_grant  <= '0;
      r_dvalid <= '0;
      r_rr     <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_cnt    <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_grant  <= w_take ? w_win : '0;
      r_dvalid <= w_deliver ? r_owner : '0;
      if (w_take) begin
        r_owner <= w_win;
        r_addr  <= w_win_addr;
        r_cnt   <= '0;
        if (!w_win[REQ_SPR]) begin
          r_rr <= ~r_rr;
        end
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_deliver) begin
        r_dout <= rom_data;
      end
      if (w_expire) begin
        r_terr <= 1'b1;
      end
    end
  end

  // Line strobe runs off the pixel enable, independent of the fetch FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hbl_d     <= 1'b0;
      r_spr_start <= 1'b0;
      r_spr_line  <= '0;
    end else begin
      r_spr_start <= clk_pix & hbl & ~r_hbl_d;
      if (clk_pix) begin
        r_hbl_d <= hbl;
        if (hbl && !r_hbl_d) begin
          r_spr_line <= vc + 9'd1;
        end
      end
    end
  end

  assign grant          = r_grant;
  assign dvalid         = r_dvalid;
  assign dout           = r_dout;
  assign rom_req        = (r_state == ISSUE);
  assign rom_addr       = r_addr;
  assign timeout_err    = r_terr;
  assign spr_line_start = r_spr_start;
  assign spr_line       = r_spr_line;

endmodule
